pipe_control_unit: RTL and testbench
====================================

Name: pipe_control_unit

Overview:
- Parametrised successor to the single-cycle opcode decoder for the pipelined MIPS core.
- Decodes opcode/funct in ID and carries the control word through the EX, MEM and WB pipeline registers.
- Inserts bubbles on stall/flush, adds JR decode and computes the destination register (rt/rd/link).
- Sits between the IF/ID register and the datapath stage registers; its outputs drive the datapath.

Parameters:
- ALUOP_W, 4, ALU operation code width; must be >= 4.
- REG_ADDR_W, 5, register-file address width.
- LINK_REG, 31, destination register written by JAL.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  instruction in ID is real; 0 decodes as bubble.
- id_op  in  6  opcode.
- id_funct  in  6  funct field.
- id_rt  in  REG_ADDR_W  rt field.
- id_rd  in  REG_ADDR_W  rd field.
- stall  in  1  hold ID upstream; inject bubble into EX.
- flush  in  1  kill ID instruction; inject bubble into EX.
- id_jump, id_jr, id_branch_eq, id_branch_ne  out  1 each  combinational ID-stage PC control.
- id_illegal  out  1  valid but unsupported opcode/funct.
- ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  out  1 each.
- ex_alu_op  out  ALUOP_W.
- ex_write_reg  out  REG_ADDR_W.
- mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write  out  1 each.
- mem_write_reg  out  REG_ADDR_W.
- wb_mem_to_reg, wb_reg_write  out  1 each.
- wb_write_reg  out  REG_ADDR_W.

Behaviour:
- Clock is clk; reset is synchronous and active-high, sampled on the rising edge.
- Decode (combinational), giving alu_src / mem_to_reg / reg_write / mem_read / mem_write / alu_op:
  - R-type (0x00): 0/0/1/0/0/7, dst=rd.
  - JR (op 0x00, funct 0x08): reg_write=0, alu_op=7, id_jr=1.
  - ADDI 0x08: 1/0/1/0/0/4, dst=rt.
  - ANDI 0x0c: as ADDI with alu_op 3.
  - ORI 0x0d: as ADDI with alu_op 5.
  - LUI 0x0f: as ADDI with alu_op 2.
  - LW 0x23: 1/1/1/1/0/8, dst=rt.
  - SW 0x2b: 1/0/0/0/1/9.
  - BEQ 0x04 / BNE 0x05: alu_op 1, id_branch_eq / id_branch_ne=1.
  - J 0x02: id_jump=1, alu_op 0.
  - JAL 0x03: id_jump=1, reg_write=1, alu_op 6, dst=LINK_REG.
  - Any other opcode: all-zero word; id_illegal=id_valid.
- alu_op values are zero-extended to ALUOP_W.
- Bubble = all enables (reg_write, mem_read, mem_write, mem_to_reg) 0, alu_op 0, write_reg 0.
- ID outputs (id_jump, id_jr, id_branch_*) are gated by id_valid and forced to 0 when flush=1.
- Pipeline registers: EX <- decode (or bubble), MEM <- EX, WB <- MEM, every cycle.
- Latency: an ID instruction appears on ex_* 1 cycle later, mem_* 2, wb_* 3.
- stall=1 or flush=1 or id_valid=0 -> EX loads a bubble. MEM/WB still advance (no upstream freeze of later stages).
- stall and flush together -> single bubble; identical to either alone.
- reg_write with destination 0: write_reg=0 and reg_write forced to 0 (no write to $zero).
- Reset: all ex_/mem_/wb_ outputs 0 on the next edge. A reset mid-stream discards all in-flight control (three bubbles follow).
- Back-to-back stalls: one bubble per stalled cycle; the decode of the held instruction enters EX on the first non-stall cycle.

Optional Feature:
- Macro: PIPE_CTRL_LOAD_USE_EN.
- When defined, adds input id_rs (REG_ADDR_W) and output hazard_stall (1, combinational).
- hazard_stall = ex_mem_read & (ex_write_reg != 0) & (ex_write_reg == id_rs | (ex_write_reg == id_rt & rt_is_source)) & id_valid.
- rt_is_source = R-type, BEQ, BNE, SW.
- hazard_stall is ORed internally with stall, so EX gets a bubble automatically. The upstream must also use hazard_stall to hold PC and IF/ID.
- When undefined: no extra ports; load-use hazards are the external hazard unit's job via stall.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode/funct localparams (OP_RTYPE, OP_ADDI, …, FUNCT_JR);
  - ALU op codes (ALU_OP_R=7, ALU_OP_ADD=4, …);
  - control-word struct/bit-index constants and the BUBBLE constant.
- One natural sub-module: pipe_ctrl_decode (pure combinational opcode/funct -> control word + dst select).
- The staging registers stay in the top.

Test Plan:
- Reset held 2 cycles during a LW stream -> all ex_/mem_/wb_ outputs 0 in the cycle after reset; first post-reset LW reaches wb_reg_write=1 exactly 3 cycles after issue.
- ADDI rt=5, then R-type rd=9, then JAL -> ex_write_reg 5, 9, 31 on consecutive cycles; ex_alu_op 4, 7, 6; wb_* mirrors 2 cycles later.
- LW then stall=1 for 2 cycles on the next instruction -> ex_* shows two bubbles (all enables 0); LW continues to mem then wb unaffected.
- BEQ with flush=1 same cycle -> id_branch_eq=0, EX bubble; R-type funct 0x08 -> id_jr=1, ex_reg_write=0; op 0x3f valid -> id_illegal=1, EX bubble.
- R-type with rd=0 -> ex_reg_write=0, ex_write_reg=0.
- With PIPE_CTRL_LOAD_USE_EN: LW rt=8 followed by ADD rs=8 -> hazard_stall=1 for one cycle, one bubble in EX. LW rt=8 followed by ADDI rt=8 (rt not a source) -> hazard_stall=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, ALU op codes,
// per-stage control words and the bubble constant.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  // Native width of the ALU op codes; the top zero-extends to ALUOP_W.
  localparam int unsigned CTRL_ALUOP_W = 4;

  localparam logic [CTRL_ALUOP_W-1:0] ALU_OP_NONE  = 4'd0;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_OP_SUB   = 4'd1;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_OP_LUI   = 4'd2;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_OP_AND   = 4'd3;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_OP_ADD   = 4'd4;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_OP_OR    = 4'd5;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_OP_LINK  = 4'd6;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_OP_R     = 4'd7;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_OP_LOAD  = 4'd8;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_OP_STORE = 4'd9;

  typedef struct packed {
    logic                    alu_src;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic                    reg_write;
    logic [CTRL_ALUOP_W-1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RT   = 2'd1,
    DST_RD   = 2'd2,
    DST_LINK = 2'd3
  } dst_sel_t;

  localparam ctrl_t BUBBLE = '0;

  function automatic mem_ctrl_t to_mem(input ctrl_t c);
    return '{mem_read: c.mem_read, mem_write: c.mem_write,
             mem_to_reg: c.mem_to_reg, reg_write: c.reg_write};
  endfunction

  function automatic wb_ctrl_t to_wb(input mem_ctrl_t c);
    return '{mem_to_reg: c.mem_to_reg, reg_write: c.reg_write};
  endfunction

  // Instructions that read rt as an operand (rather than writing it).
  function automatic logic rt_is_source(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Pure combinational opcode/funct decode into a control word, destination
// select and raw (ungated) ID-stage PC-control flags.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output dst_sel_t   dst_sel,
  output logic       jump,
  output logic       jr,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic       known
);

  // Opcode table; unknown opcodes fall through to the all-zero word.
  always_comb begin
    ctrl      = BUBBLE;
    dst_sel   = DST_NONE;
    jump      = 1'b0;
    jr        = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    known     = 1'b1;
    case (op)
      OP_RTYPE: begin
        ctrl.alu_op = ALU_OP_R;
        if (funct == FUNCT_JR) begin
          jr = 1'b1;
        end else begin
          ctrl.reg_write = 1'b1;
          dst_sel        = DST_RD;
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        dst_sel        = DST_RT;
        case (op)
          OP_ANDI: ctrl.alu_op = ALU_OP_AND;
          OP_ORI:  ctrl.alu_op = ALU_OP_OR;
          OP_LUI:  ctrl.alu_op = ALU_OP_LUI;
          default: ctrl.alu_op = ALU_OP_ADD;
        endcase
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALU_OP_LOAD;
        dst_sel         = DST_RT;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_OP_STORE;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_OP_SUB;
        branch_eq   = 1'b1;
      end
      OP_BNE: begin
        ctrl.alu_op = ALU_OP_SUB;
        branch_ne   = 1'b1;
      end
      OP_J: begin
        jump = 1'b1;
      end
      OP_JAL: begin
        jump           = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_LINK;
        dst_sel        = DST_LINK;
      end
      default: known = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes in ID and carries the control word through
// EX/MEM/WB registers, injecting bubbles on stall/flush/invalid.
// Optional macro PIPE_CTRL_LOAD_USE_EN adds internal load-use detection
// (id_rs input, hazard_stall output).
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W    = 4,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LINK_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [5:0]            id_op,
  input  logic [5:0]            id_funct,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  stall,
  input  logic                  flush,
`ifdef PIPE_CTRL_LOAD_USE_EN
  input  logic [REG_ADDR_W-1:0] id_rs,
  output logic                  hazard_stall,
`endif
  output logic                  id_jump,
  output logic                  id_jr,
  output logic                  id_branch_eq,
  output logic                  id_branch_ne,
  output logic                  id_illegal,
  output logic                  ex_alu_src,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_write_reg,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg,
  output logic                  mem_reg_write,
  output logic [REG_ADDR_W-1:0] mem_write_reg,
  output logic                  wb_mem_to_reg,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_write_reg
);

  ctrl_t                 dec_ctrl;
  dst_sel_t              dec_dst;
  logic                  dec_jump, dec_jr, dec_beq, dec_bne, dec_known;
  ctrl_t                 id_ctrl;
  logic [REG_ADDR_W-1:0] id_write_reg;
  logic                  load_use;
  logic                  ex_bubble;

  ctrl_t                 ex_ctrl_d, ex_ctrl_q;
  logic [REG_ADDR_W-1:0] ex_write_reg_d, ex_write_reg_q;
  mem_ctrl_t             mem_ctrl_d, mem_ctrl_q;
  logic [REG_ADDR_W-1:0] mem_write_reg_d, mem_write_reg_q;
  wb_ctrl_t              wb_ctrl_d, wb_ctrl_q;
  logic [REG_ADDR_W-1:0] wb_write_reg_d, wb_write_reg_q;

  pipe_ctrl_decode u_decode (
    .op        (id_op),
    .funct     (id_funct),
    .ctrl      (dec_ctrl),
    .dst_sel   (dec_dst),
    .jump      (dec_jump),
    .jr        (dec_jr),
    .branch_eq (dec_beq),
    .branch_ne (dec_bne),
    .known     (dec_known)
  );

  // PC control only for a live instruction that is not being flushed.
  assign id_jump      = dec_jump & id_valid & ~flush;
  assign id_jr        = dec_jr   & id_valid & ~flush;
  assign id_branch_eq = dec_beq  & id_valid & ~flush;
  assign id_branch_ne = dec_bne  & id_valid & ~flush;
  assign id_illegal   = id_valid & ~dec_known;

`ifdef PIPE_CTRL_LOAD_USE_EN
  // A load in EX whose target is read by the ID instruction must wait a cycle.
  assign hazard_stall = ex_ctrl_q.mem_read & (ex_write_reg_q != '0) & id_valid &
                        ((ex_write_reg_q == id_rs) |
                         ((ex_write_reg_q == id_rt) & rt_is_source(id_op)));
  assign load_use     = hazard_stall;
`else
  assign load_use     = 1'b0;
`endif

  assign ex_bubble = stall | flush | ~id_valid | load_use;

  // Destination select; writes to register 0 are suppressed entirely.
  always_comb begin
    id_ctrl = dec_ctrl;
    case (dec_dst)
      DST_RT:   id_write_reg = id_rt;
      DST_RD:   id_write_reg = id_rd;
      DST_LINK: id_write_reg = REG_ADDR_W'(LINK_REG);
      default:  id_write_reg = '0;
    endcase
    if (id_write_reg == '0) id_ctrl.reg_write = 1'b0;
  end

  // Next-state for the stage registers: EX takes decode or a bubble, later stages shift.
  always_comb begin
    ex_ctrl_d       = ex_bubble ? BUBBLE : id_ctrl;
    ex_write_reg_d  = ex_bubble ? '0 : id_write_reg;
    mem_ctrl_d      = to_mem(ex_ctrl_q);
    mem_write_reg_d = ex_write_reg_q;
    wb_ctrl_d       = to_wb(mem_ctrl_q);
    wb_write_reg_d  = mem_write_reg_q;
  end

  // Stage registers; reset discards all in-flight control.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl_q       <= BUBBLE;
      ex_write_reg_q  <= '0;
      mem_ctrl_q      <= '0;
      mem_write_reg_q <= '0;
      wb_ctrl_q       <= '0;
      wb_write_reg_q  <= '0;
    end else begin
      ex_ctrl_q       <= ex_ctrl_d;
      ex_write_reg_q  <= ex_write_reg_d;
      mem_ctrl_q      <= mem_ctrl_d;
      mem_write_reg_q <= mem_write_reg_d;
      wb_ctrl_q       <= wb_ctrl_d;
      wb_write_reg_q  <= wb_write_reg_d;
    end
  end

  assign ex_alu_src     = ex_ctrl_q.alu_src;
  assign ex_mem_read    = ex_ctrl_q.mem_read;
  assign ex_mem_write   = ex_ctrl_q.mem_write;
  assign ex_mem_to_reg  = ex_ctrl_q.mem_to_reg;
  assign ex_reg_write   = ex_ctrl_q.reg_write;
  assign ex_alu_op      = ALUOP_W'(ex_ctrl_q.alu_op);
  assign ex_write_reg   = ex_write_reg_q;
  assign mem_mem_read   = mem_ctrl_q.mem_read;
  assign mem_mem_write  = mem_ctrl_q.mem_write;
  assign mem_mem_to_reg = mem_ctrl_q.mem_to_reg;
  assign mem_reg_write  = mem_ctrl_q.reg_write;
  assign mem_write_reg  = mem_write_reg_q;
  assign wb_mem_to_reg  = wb_ctrl_q.mem_to_reg;
  assign wb_reg_write   = wb_ctrl_q.reg_write;
  assign wb_write_reg   = wb_write_reg_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed, table-driven bench for pipe_control_unit plus hand-written
// sequences for reset, stall and (optionally) load-use behaviour.
module tb_pipe_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] id_op, id_funct;
  logic [4:0] id_rt, id_rd;
  logic       stall, flush;
  logic       id_jump, id_jr, id_branch_eq, id_branch_ne, id_illegal;
  logic       ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic [3:0] ex_alu_op;
  logic [4:0] ex_write_reg;
  logic       mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
  logic [4:0] mem_write_reg;
  logic       wb_mem_to_reg, wb_reg_write;
  logic [4:0] wb_write_reg;
`ifdef PIPE_CTRL_LOAD_USE_EN
  logic [4:0] id_rs;
  logic       hazard_stall;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pipe_control_unit #(.ALUOP_W(4), .REG_ADDR_W(5), .LINK_REG(31)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_op          (id_op),
    .id_funct       (id_funct),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .stall          (stall),
    .flush          (flush),
`ifdef PIPE_CTRL_LOAD_USE_EN
    .id_rs          (id_rs),
    .hazard_stall   (hazard_stall),
`endif
    .id_jump        (id_jump),
    .id_jr          (id_jr),
    .id_branch_eq   (id_branch_eq),
    .id_branch_ne   (id_branch_ne),
    .id_illegal     (id_illegal),
    .ex_alu_src     (ex_alu_src),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_reg_write   (ex_reg_write),
    .ex_alu_op      (ex_alu_op),
    .ex_write_reg   (ex_write_reg),
    .mem_mem_read   (mem_mem_read),
    .mem_mem_write  (mem_mem_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_reg_write  (mem_reg_write),
    .mem_write_reg  (mem_write_reg),
    .wb_mem_to_reg  (wb_mem_to_reg),
    .wb_reg_write   (wb_reg_write),
    .wb_write_reg   (wb_write_reg)
  );

  // e_id = {jump, jr, beq, bne, illegal}; e_en = {alu_src, mem_read, mem_write, mem_to_reg, reg_write}
  typedef struct {
    logic       valid;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       st;
    logic       fl;
    logic [4:0] e_id;
    logic [4:0] e_en;
    logic [3:0] e_alu;
    logic [4:0] e_wr;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [5:0] fn,
                              input logic [4:0] rt, input logic [4:0] rd,
                              input logic st, input logic fl, input logic [4:0] eid,
                              input logic [4:0] een, input logic [3:0] ealu,
                              input logic [4:0] ewr);
    vec_t r;
    r.valid = v; r.op = op; r.funct = fn; r.rt = rt; r.rd = rd; r.st = st; r.fl = fl;
    r.e_id = eid; r.e_en = een; r.e_alu = ealu; r.e_wr = ewr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic st, input logic fl);
    id_valid = v; id_op = op; id_funct = fn; id_rt = rt; id_rd = rd; stall = st; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_stages();
    return {2'b0, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
            ex_alu_op, ex_write_reg, mem_mem_read, mem_mem_write, mem_mem_to_reg,
            mem_reg_write, mem_write_reg, wb_mem_to_reg, wb_reg_write, wb_write_reg};
  endfunction

  vec_t vecs[21];
  vec_t p1, p2;

  initial begin
    reset = 1'b1;
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
`ifdef PIPE_CTRL_LOAD_USE_EN
    id_rs = 5'd0;
`endif

    //               v  op     funct  rt  rd  st fl  id        en        alu wr
    vecs[0]  = mk(1, 6'h08, 6'h00, 5,  0,  0, 0, 5'b00000, 5'b10001, 4, 5);
    vecs[1]  = mk(1, 6'h00, 6'h20, 3,  9,  0, 0, 5'b00000, 5'b00001, 7, 9);
    vecs[2]  = mk(1, 6'h03, 6'h00, 2,  4,  0, 0, 5'b10000, 5'b00001, 6, 31);
    vecs[3]  = mk(1, 6'h23, 6'h00, 7,  0,  0, 0, 5'b00000, 5'b11011, 8, 7);
    vecs[4]  = mk(1, 6'h2b, 6'h00, 6,  0,  0, 0, 5'b00000, 5'b10100, 9, 0);
    vecs[5]  = mk(1, 6'h04, 6'h00, 1,  2,  0, 1, 5'b00000, 5'b00000, 0, 0);
    vecs[6]  = mk(1, 6'h04, 6'h00, 1,  2,  0, 0, 5'b00100, 5'b00000, 1, 0);
    vecs[7]  = mk(1, 6'h05, 6'h00, 1,  2,  0, 0, 5'b00010, 5'b00000, 1, 0);
    vecs[8]  = mk(1, 6'h00, 6'h08, 0,  0,  0, 0, 5'b01000, 5'b00000, 7, 0);
    vecs[9]  = mk(1, 6'h3f, 6'h00, 4,  4,  0, 0, 5'b00001, 5'b00000, 0, 0);
    vecs[10] = mk(1, 6'h00, 6'h20, 3,  0,  0, 0, 5'b00000, 5'b00000, 7, 0);
    vecs[11] = mk(1, 6'h0c, 6'h00, 0,  0,  0, 0, 5'b00000, 5'b10000, 3, 0);
    vecs[12] = mk(1, 6'h0d, 6'h00, 12, 0,  0, 0, 5'b00000, 5'b10001, 5, 12);
    vecs[13] = mk(1, 6'h0f, 6'h00, 13, 0,  0, 0, 5'b00000, 5'b10001, 2, 13);
    vecs[14] = mk(1, 6'h02, 6'h00, 0,  0,  0, 0, 5'b10000, 5'b00000, 0, 0);
    vecs[15] = mk(0, 6'h08, 6'h00, 5,  0,  0, 0, 5'b00000, 5'b00000, 0, 0);
    vecs[16] = mk(1, 6'h08, 6'h00, 5,  0,  1, 0, 5'b00000, 5'b00000, 0, 0);
    vecs[17] = mk(1, 6'h02, 6'h00, 0,  0,  1, 0, 5'b10000, 5'b00000, 0, 0);
    vecs[18] = mk(0, 6'h03, 6'h00, 0,  0,  0, 0, 5'b00000, 5'b00000, 0, 0);
    vecs[19] = mk(1, 6'h08, 6'h00, 5,  0,  1, 1, 5'b00000, 5'b00000, 0, 0);
    vecs[20] = mk(1, 6'h0d, 6'h00, 21, 0,  0, 0, 5'b00000, 5'b10001, 5, 21);

    // Reset state.
    step();
    step();
    chk("reset_state", all_stages(), 32'd0);

    // LW stream, then reset held two cycles mid-stream.
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 6'h23, 6'h00, 5'd4, 5'd0, 1'b0, 1'b0);
    repeat (3) step();
    chk("stream_wb_rw", {31'd0, wb_reg_write}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("reset_mid_1", all_stages(), 32'd0);
    step();
    chk("reset_mid_2", all_stages(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_rst_ex_mr", {31'd0, ex_mem_read}, 32'd1);
    chk("post_rst_wb_e1", {31'd0, wb_reg_write}, 32'd0);
    @(negedge clk);
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    chk("post_rst_wb_e2", {31'd0, wb_reg_write}, 32'd0);
    step();
    chk("post_rst_wb_e3", {26'd0, wb_reg_write, wb_write_reg}, {26'd0, 1'b1, 5'd4});
    step();
    step();

    // Table-driven decode and pipeline propagation.
    p1 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    p2 = p1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].op, vecs[i].funct, vecs[i].rt, vecs[i].rd,
            vecs[i].st, vecs[i].fl);
      #1;
      chk($sformatf("v%0d id", i),
          {27'd0, id_jump, id_jr, id_branch_eq, id_branch_ne, id_illegal}, {27'd0, vecs[i].e_id});
      step();
      chk($sformatf("v%0d ex_en", i),
          {27'd0, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write},
          {27'd0, vecs[i].e_en});
      chk($sformatf("v%0d ex_alu_op", i), {28'd0, ex_alu_op}, {28'd0, vecs[i].e_alu});
      chk($sformatf("v%0d ex_wr", i), {27'd0, ex_write_reg}, {27'd0, vecs[i].e_wr});
      chk($sformatf("v%0d mem", i),
          {23'd0, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_write_reg},
          {23'd0, p1.e_en[3:0], p1.e_wr});
      chk($sformatf("v%0d wb", i),
          {25'd0, wb_mem_to_reg, wb_reg_write, wb_write_reg},
          {25'd0, p2.e_en[1:0], p2.e_wr});
      p2 = p1;
      p1 = vecs[i];
    end

    // LW followed by an instruction stalled for two cycles.
    @(negedge clk);
    drive(1'b1, 6'h23, 6'h00, 5'd7, 5'd0, 1'b0, 1'b0);
    step();
    chk("st_ex_lw", {30'd0, ex_mem_read, ex_reg_write}, 32'd3);
    @(negedge clk);
    drive(1'b1, 6'h00, 6'h20, 5'd3, 5'd11, 1'b1, 1'b0);
    step();
    chk("st_ex_bub1", {27'd0, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write}, 32'd0);
    chk("st_mem_lw", {26'd0, mem_mem_read, mem_write_reg}, {26'd0, 1'b1, 5'd7});
    step();
    chk("st_ex_bub2", {27'd0, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write}, 32'd0);
    chk("st_wb_lw", {25'd0, wb_mem_to_reg, wb_reg_write, wb_write_reg}, {25'd0, 2'b11, 5'd7});
    @(negedge clk);
    stall = 1'b0;
    step();
    chk("st_ex_add", {26'd0, ex_reg_write, ex_write_reg}, {26'd0, 1'b1, 5'd11});
    chk("st_wb_bub", {30'd0, wb_mem_to_reg, wb_reg_write}, 32'd0);

`ifdef PIPE_CTRL_LOAD_USE_EN
    // Load-use: ADD reading the loaded register must get exactly one bubble.
    @(negedge clk);
    drive(1'b1, 6'h23, 6'h00, 5'd8, 5'd0, 1'b0, 1'b0);
    id_rs = 5'd0;
    step();
    @(negedge clk);
    drive(1'b1, 6'h00, 6'h20, 5'd1, 5'd10, 1'b0, 1'b0);
    id_rs = 5'd8;
    #1;
    chk("lu_hazard_on", {31'd0, hazard_stall}, 32'd1);
    step();
    chk("lu_ex_bubble", {30'd0, ex_mem_read, ex_reg_write}, 32'd0);
    @(negedge clk);
    #1;
    chk("lu_hazard_off", {31'd0, hazard_stall}, 32'd0);
    step();
    chk("lu_ex_add", {26'd0, ex_reg_write, ex_write_reg}, {26'd0, 1'b1, 5'd10});
    @(negedge clk);
    drive(1'b1, 6'h23, 6'h00, 5'd8, 5'd0, 1'b0, 1'b0);
    id_rs = 5'd0;
    step();
    @(negedge clk);
    drive(1'b1, 6'h08, 6'h00, 5'd8, 5'd0, 1'b0, 1'b0);
    id_rs = 5'd2;
    #1;
    chk("lu_addi_rt", {31'd0, hazard_stall}, 32'd0);
    step();
    chk("lu_ex_addi", {26'd0, ex_reg_write, ex_write_reg}, {26'd0, 1'b1, 5'd8});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
